// File: rtl/cpu_reset_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_reset_sequencer
//
// Generates the RESET input of the CPU core. It merges three reset sources
// into one clean, synchronous RESET sequence:
//   - power-on reset (notRESET, asynchronous assert, synchronous release)
//   - a mechanical reset button (BTN_RESET, synchronized and debounced)
//   - a single-cycle software/watchdog request (SOFT_RESET_REQ)
//
// The sequence works like this:
//   - RESET is held for at least HOLD_CYCLES cycles, and until the core
//     reports through TRESET that its internal reset chain has seen it.
//   - If the core never reports, RESET is released after ACK_TIMEOUT cycles
//     and ACK_ERR is raised.
//   - A cooldown of COOLDOWN_CYCLES follows. A request that arrives during
//     the cooldown is remembered and starts a new sequence when the cooldown
//     ends.
//
// Ports:
//   Clk             in   system clock, rising edge
//   notRESET        in   asynchronous active-low power-on reset
//   BTN_RESET       in   raw reset button, active high, asynchronous
//   SOFT_RESET_REQ  in   synchronous one-cycle reset request
//   TRESET          in   core's TRESET, high while the core is resetting
//   RESET           out  registered reset to the core, active high
//   BUSY            out  high whenever the sequencer is not idle
//   RESET_DONE      out  one-cycle pulse when a sequence finishes
//   ACK_ERR         out  sticky: the last sequence ended without an ack
//
// All outputs are driven directly from flops. No input reaches an output
// through combinational logic.
// ---------------------------------------------------------------------------
module cpu_reset_sequencer #(
  parameter int HOLD_CYCLES     = 7,   // >= 3, covers the core's 3-stage TRESET chain
  parameter int ACK_TIMEOUT     = 32,  // > HOLD_CYCLES
  parameter int COOLDOWN_CYCLES = 4,   // >= 1
  parameter int DEBOUNCE_BITS   = 4    // button must be stable 2**DEBOUNCE_BITS cycles
) (
  input  logic Clk,
  input  logic notRESET,
  input  logic BTN_RESET,
  input  logic SOFT_RESET_REQ,
  input  logic TRESET,
  output logic RESET,
  output logic BUSY,
  output logic RESET_DONE,
  output logic ACK_ERR
);

  // -------------------------------------------------------------------------
  // Counter sizing. One counter serves both ASSERT and COOLDOWN. Every state
  // leaves at or before its own terminal count, so the counter never wraps.
  // -------------------------------------------------------------------------
  localparam int CNT_MAX = (ACK_TIMEOUT > COOLDOWN_CYCLES) ? ACK_TIMEOUT
                                                           : COOLDOWN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] COOL_LAST    = CW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Button path: a 2-flop synchronizer, then a debouncer.
  //
  // The debounced level follows the synchronized input only after the two
  // have differed for 2**DEBOUNCE_BITS consecutive cycles. Any cycle in which
  // they agree clears the count, so contact bounce never gets through.
  // btn_req is a registered one-cycle pulse on each 0->1 change of the
  // debounced level. A release of the button never requests a reset.
  // -------------------------------------------------------------------------
  logic                     btn_sync_0;
  logic                     btn_sync_1;
  logic                     btn_level;
  logic [DEBOUNCE_BITS-1:0] btn_cnt;
  logic                     btn_req;

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every flop samples values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge Clk or negedge notRESET) begin
    if (!notRESET) begin
      btn_sync_0 <= 1'b0;
      btn_sync_1 <= 1'b0;
      btn_level  <= 1'b0;
      btn_cnt    <= '0;
      btn_req    <= 1'b0;
    end else begin
      btn_sync_0 <= BTN_RESET;
      btn_sync_1 <= btn_sync_0;
      btn_req    <= 1'b0;
      if (btn_sync_1 == btn_level) begin
        btn_cnt <= '0;
      end else if (btn_cnt == '1) begin
        // This is the last cycle of the stable window, so accept the new level.
        btn_level <= btn_sync_1;
        btn_cnt   <= '0;
        btn_req   <= btn_sync_1;
      end else begin
        btn_cnt <= btn_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Merged request. A button request and a soft request in the same cycle
  // count as one request.
  // -------------------------------------------------------------------------
  logic req;

  // NOTE: a combinational block assigns its output on every path, so no
  // latch can be inferred.
  always_comb begin
    req = btn_req | SOFT_RESET_REQ;
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // -------------------------------------------------------------------------
  state_t        state;
  logic [CW-1:0] cnt;
  logic          ack;      // TRESET has been seen during this ASSERT phase
  logic          pending;  // a request arrived during COOLDOWN

  // The core may still have TRESET high on the exit edge without the
  // registered ack being set yet. Accept either one.
  logic acked;
  always_comb begin
    acked = ack | TRESET;
  end

  always_ff @(posedge Clk or negedge notRESET) begin
    if (!notRESET) begin
      // Power-on starts in ASSERT, so the core is held in reset from the
      // first cycle and the full hold time runs after release.
      state      <= ST_ASSERT;
      cnt        <= '0;
      ack        <= 1'b0;
      pending    <= 1'b0;
      RESET      <= 1'b1;
      BUSY       <= 1'b1;
      RESET_DONE <= 1'b0;
      ACK_ERR    <= 1'b0;
    end else begin
      RESET_DONE <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_ASSERT;
            cnt   <= '0;
            ack   <= 1'b0;
            RESET <= 1'b1;
            BUSY  <= 1'b1;
          end
        end

        ST_ASSERT: begin
          // Any request that arrives now is absorbed: it is not queued and
          // does not restart the counter.
          if (TRESET) begin
            ack <= 1'b1;
          end
          if (cnt >= HOLD_LAST && acked) begin
            state   <= ST_COOLDOWN;
            cnt     <= '0;
            RESET   <= 1'b0;
            ACK_ERR <= 1'b0;
          end else if (cnt == TIMEOUT_LAST) begin
            // The core never answered. Release RESET anyway so the system
            // cannot stay stuck in reset, and flag it.
            state   <= ST_COOLDOWN;
            cnt     <= '0;
            RESET   <= 1'b0;
            ACK_ERR <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_COOLDOWN: begin
          if (cnt == COOL_LAST) begin
            // A request on this final edge counts the same as an earlier
            // pending one.
            if (pending || req) begin
              state   <= ST_ASSERT;
              cnt     <= '0;
              ack     <= 1'b0;
              pending <= 1'b0;
              RESET   <= 1'b1;
            end else begin
              state      <= ST_IDLE;
              cnt        <= '0;
              BUSY       <= 1'b0;
              RESET_DONE <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (req) begin
              pending <= 1'b1;
            end
          end
        end

        default: begin
          // Unreachable encoding: recover by running a full reset sequence.
          state   <= ST_ASSERT;
          cnt     <= '0;
          ack     <= 1'b0;
          pending <= 1'b0;
          RESET   <= 1'b1;
          BUSY    <= 1'b1;
        end
      endcase
    end
  end

endmodule
